// File: rtl/dpsram_be_init.sv
// True dual-port synchronous SRAM with per-byte write enables, selectable
// read latency, defined same-address collision behaviour and a post-reset
// init sweep that writes INIT_VAL to every word.
module dpsram_be_init #(
    parameter int unsigned     W           = 32,
    parameter int unsigned     N           = 128,
    parameter int unsigned     RD_LAT      = 1,
    parameter int unsigned     WRITE_FIRST = 1,
    parameter logic [W-1:0]    INIT_VAL    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_busy,
    output logic                   collision,
    input  logic                   en0,
    input  logic                   wen0,
    input  logic [W/8-1:0]         be0,
    input  logic [$clog2(N)-1:0]   addr0,
    input  logic [W-1:0]           din0,
    output logic [W-1:0]           dout0,
    output logic                   dout0_vld,
    input  logic                   en1,
    input  logic                   wen1,
    input  logic [W/8-1:0]         be1,
    input  logic [$clog2(N)-1:0]   addr1,
    input  logic [W-1:0]           din1,
    output logic [W-1:0]           dout1,
    output logic                   dout1_vld
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned NB = W / 8;

    // Parameter legality checks at elaboration
    if (W == 0 || (W % 8) != 0) begin : g_bad_w
        $error("dpsram_be_init: W must be a nonzero multiple of 8");
    end
    if (N < 2) begin : g_bad_n
        $error("dpsram_be_init: N must be at least 2");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("dpsram_be_init: RD_LAT must be 1 or 2");
    end

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mem [N];

    logic            in_range0, in_range1;
    logic            run, init_we;
    logic            rd0, rd1, wr0, wr1;
    logic [W-1:0]    rd_word0, rd_word1;

    // Address range qualification; only non-power-of-two depths can overflow
    if (N == (32'd1 << AW)) begin : g_pow2
        assign in_range0 = 1'b1;
        assign in_range1 = 1'b1;
    end else begin : g_npow2
        assign in_range0 = (32'(addr0) < N);
        assign in_range1 = (32'(addr1) < N);
    end

    assign run     = (state_q == RUN);
    assign init_we = rst_n && (state_q == INIT);
    assign rd0     = rst_n && run && en0 && !wen0;
    assign rd1     = rst_n && run && en1 && !wen1;
    assign wr0     = rst_n && run && en0 && wen0 && in_range0;
    assign wr1     = rst_n && run && en1 && wen1 && in_range1;

    // State register and sweep counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every word once, then serve requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(N - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Array write: init sweep, else byte-masked port writes (port 1 last, so it wins)
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_q] <= INIT_VAL;
        end else begin
            for (int k = 0; k < int'(NB); k++) begin
                if (wr0 && be0[k]) mem[addr0][8*k +: 8] <= din0[8*k +: 8];
            end
            for (int k = 0; k < int'(NB); k++) begin
                if (wr1 && be1[k]) mem[addr1][8*k +: 8] <= din1[8*k +: 8];
            end
        end
    end

    // Port 0 read word, with optional forwarding of a same-address port 1 write
    always_comb begin
        rd_word0 = INIT_VAL;
        if (in_range0) rd_word0 = mem[addr0];
        if (WRITE_FIRST != 0 && wr1 && (addr1 == addr0)) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (be1[k]) rd_word0[8*k +: 8] = din1[8*k +: 8];
            end
        end
    end

    // Port 1 read word, with optional forwarding of a same-address port 0 write
    always_comb begin
        rd_word1 = INIT_VAL;
        if (in_range1) rd_word1 = mem[addr1];
        if (WRITE_FIRST != 0 && wr0 && (addr0 == addr1)) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (be0[k]) rd_word1[8*k +: 8] = din0[8*k +: 8];
            end
        end
    end

    // Status outputs: busy lags the state by one edge, collision flags dual writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_busy <= 1'b1;
            collision <= 1'b0;
        end else begin
            init_busy <= (state_q == INIT);
            collision <= wr0 && wr1 && (addr0 == addr1);
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        // Single output register per port
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout0     <= '0;
                dout1     <= '0;
                dout0_vld <= 1'b0;
                dout1_vld <= 1'b0;
            end else begin
                dout0_vld <= rd0;
                dout1_vld <= rd1;
                if (rd0) dout0 <= rd_word0;
                if (rd1) dout1 <= rd_word1;
            end
        end
    end else begin : g_lat2
        logic [W-1:0] s1_data0, s1_data1;
        logic         s1_vld0, s1_vld1;

        // Array read stage followed by an output register; reset squashes both
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_data0  <= '0;
                s1_data1  <= '0;
                s1_vld0   <= 1'b0;
                s1_vld1   <= 1'b0;
                dout0     <= '0;
                dout1     <= '0;
                dout0_vld <= 1'b0;
                dout1_vld <= 1'b0;
            end else begin
                s1_vld0   <= rd0;
                s1_vld1   <= rd1;
                if (rd0) s1_data0 <= rd_word0;
                if (rd1) s1_data1 <= rd_word1;
                dout0_vld <= s1_vld0;
                dout1_vld <= s1_vld1;
                if (s1_vld0) dout0 <= s1_data0;
                if (s1_vld1) dout1 <= s1_data1;
            end
        end
    end

    // Out-of-range accesses are a usage error
    a_oor0: assert property (@(posedge clk) disable iff (!rst_n)
                             !(run && en0 && !in_range0));
    a_oor1: assert property (@(posedge clk) disable iff (!rst_n)
                             !(run && en1 && !in_range1));

endmodule

// File: tb/tb_dpsram_be_init.sv
// Bench for dpsram_be_init: two instances (RD_LAT=1/WRITE_FIRST=1 and
// RD_LAT=2/WRITE_FIRST=0) share one stimulus stream and one behavioural model.
module tb_dpsram_be_init;

    localparam int unsigned N  = 128;
    localparam logic [31:0] IV = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        en0, wen0, en1, wen1;
    logic [3:0]  be0, be1;
    logic [6:0]  addr0, addr1;
    logic [31:0] din0, din1;

    logic [31:0] dout [2][2];
    logic        vld  [2][2];
    logic        coll [2];
    logic        busy [2];

    int errors = 0;
    int checks = 0;

    dpsram_be_init #(.W(32), .N(N), .RD_LAT(1), .WRITE_FIRST(1), .INIT_VAL(IV)) dut_a (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[0]), .collision(coll[0]),
        .en0(en0), .wen0(wen0), .be0(be0), .addr0(addr0), .din0(din0),
        .dout0(dout[0][0]), .dout0_vld(vld[0][0]),
        .en1(en1), .wen1(wen1), .be1(be1), .addr1(addr1), .din1(din1),
        .dout1(dout[0][1]), .dout1_vld(vld[0][1]));

    dpsram_be_init #(.W(32), .N(N), .RD_LAT(2), .WRITE_FIRST(0), .INIT_VAL(IV)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_busy(busy[1]), .collision(coll[1]),
        .en0(en0), .wen0(wen0), .be0(be0), .addr0(addr0), .din0(din0),
        .dout0(dout[1][0]), .dout0_vld(vld[1][0]),
        .en1(en1), .wen1(wen1), .be1(be1), .addr1(addr1), .din1(din1),
        .dout1(dout[1][1]), .dout1_vld(vld[1][1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [N];
    int          sweep = 0;
    int          edge_n = 0;
    bit          have_model = 0;
    logic [31:0] exp_dout [2][2];
    logic        exp_vld  [2][2];
    logic        exp_coll;
    logic        exp_busy;
    logic [31:0] slot_d [2][2][4];
    logic        slot_v [2][2][4];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        logic        acc, r0, r1, w0, w1;
        logic [31:0] old0, old1, v;
        int          lat, s;
        if (!rst_n) begin
            have_model = 1;
            sweep      = 0;
            exp_busy   = 1'b1;
            exp_coll   = 1'b0;
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++) begin
                    exp_dout[m][p] = '0;
                    exp_vld[m][p]  = 1'b0;
                    for (int i = 0; i < 4; i++) slot_v[m][p][i] = 1'b0;
                end
        end else begin
            acc      = (sweep >= int'(N));
            exp_busy = !acc;
            if (!acc) begin
                if (sweep == int'(N) - 1)
                    for (int i = 0; i < int'(N); i++) mem_m[i] = IV;
                sweep++;
            end
            r0 = acc && en0 && !wen0;
            r1 = acc && en1 && !wen1;
            w0 = acc && en0 && wen0;
            w1 = acc && en1 && wen1;
            old0 = mem_m[addr0];
            old1 = mem_m[addr1];
            exp_coll = w0 && w1 && (addr0 == addr1);
            if (w0) mem_m[addr0] = merge(mem_m[addr0], din0, be0);
            if (w1) mem_m[addr1] = merge(mem_m[addr1], din1, be1);
            for (int m = 0; m < 2; m++) begin
                lat = (m == 0) ? 1 : 2;
                s   = (edge_n + lat - 1) % 4;
                if (r0) begin
                    v = (m == 0 && w1 && addr1 == addr0) ? mem_m[addr0] : old0;
                    slot_v[m][0][s] = 1'b1;
                    slot_d[m][0][s] = v;
                end
                if (r1) begin
                    v = (m == 0 && w0 && addr0 == addr1) ? mem_m[addr1] : old1;
                    slot_v[m][1][s] = 1'b1;
                    slot_d[m][1][s] = v;
                end
                for (int p = 0; p < 2; p++) begin
                    exp_vld[m][p] = slot_v[m][p][edge_n % 4];
                    if (slot_v[m][p][edge_n % 4]) exp_dout[m][p] = slot_d[m][p][edge_n % 4];
                    slot_v[m][p][edge_n % 4] = 1'b0;
                end
            end
        end
        edge_n++;
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        if (have_model) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("busy_m%0d", m), 32'(busy[m]), 32'(exp_busy));
                chk($sformatf("coll_m%0d", m), 32'(coll[m]), 32'(exp_coll));
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("vld_m%0d_p%0d", m, p), 32'(vld[m][p]), 32'(exp_vld[m][p]));
                    chk($sformatf("dout_m%0d_p%0d", m, p), dout[m][p], exp_dout[m][p]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        en0 = 1'b0; en1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    endtask

    task automatic set_port(input int p, input logic en, input logic wen, input logic [3:0] be,
                            input logic [6:0] a, input logic [31:0] d);
        if (p == 0) begin
            en0 = en; wen0 = wen; be0 = be; addr0 = a; din0 = d;
        end else begin
            en1 = en; wen1 = wen; be1 = be; addr1 = a; din1 = d;
        end
    endtask

    task automatic wr(input int p, input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        set_port(p, 1'b1, 1'b1, be, a, d);
        tick();
        idle();
    endtask

    task automatic rd_check(input int p, input logic [6:0] a, input logic [31:0] lit);
        set_port(p, 1'b1, 1'b0, 4'h0, a, 32'h0);
        tick();
        idle();
        chk("lat1_data", dout[0][p], lit);
        chk("lat1_vld", 32'(vld[0][p]), 32'd1);
        tick();
        chk("lat1_vld_one_cycle", 32'(vld[0][p]), 32'd0);
        chk("lat2_data", dout[1][p], lit);
        chk("lat2_vld", 32'(vld[1][p]), 32'd1);
        tick();
        chk("lat2_vld_one_cycle", 32'(vld[1][p]), 32'd0);
    endtask

    // Counts cycles of init_busy after rst_n has just been released
    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (busy[0] && busy[1]) n++;
            else break;
        end
        chk(name, 32'(n), 32'd128);
    endtask

    initial begin
        rst_n = 1'b0;
        be0 = '0; be1 = '0; addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
        idle();
        tick(); tick(); tick();
        chk("reset_busy", 32'(busy[0]), 32'd1);
        chk("reset_vld", 32'(vld[1][0]), 32'd0);
        rst_n = 1'b1;
        count_busy("init_sweep_len");

        // init contents
        rd_check(0, 7'd0, IV);
        rd_check(1, 7'd64, IV);
        rd_check(0, 7'd127, IV);

        // latency
        wr(0, 7'd5, 32'h1234_5678, 4'hF);
        rd_check(0, 7'd5, 32'h1234_5678);

        // byte enables
        wr(0, 7'd9, 32'hAABB_CCDD, 4'hF);
        wr(1, 7'd9, 32'h1122_3344, 4'b0101);
        chk("model_be", mem_m[9], 32'hAA22_CC44);
        rd_check(1, 7'd9, 32'hAA22_CC44);

        // write/write collision
        wr(0, 7'd20, 32'h5A5A_5A5A, 4'hF);
        set_port(0, 1'b1, 1'b1, 4'b0011, 7'd20, 32'h0000_00FF);
        set_port(1, 1'b1, 1'b1, 4'b0110, 7'd20, 32'hFFFF_FF00);
        tick();
        idle();
        chk("coll_a", 32'(coll[0]), 32'd1);
        chk("coll_b", 32'(coll[1]), 32'd1);
        tick();
        chk("coll_a_off", 32'(coll[0]), 32'd0);
        chk("coll_b_off", 32'(coll[1]), 32'd0);
        chk("model_ww", mem_m[20], 32'h5AFF_FFFF);
        rd_check(0, 7'd20, 32'h5AFF_FFFF);

        // read/write bypass
        wr(0, 7'd30, 32'h0, 4'hF);
        set_port(0, 1'b1, 1'b0, 4'h0, 7'd30, 32'h0);
        set_port(1, 1'b1, 1'b1, 4'hF, 7'd30, 32'hCAFE_F00D);
        tick();
        idle();
        chk("bypass_wf1", dout[0][0], 32'hCAFE_F00D);
        chk("bypass_wf1_vld", 32'(vld[0][0]), 32'd1);
        chk("bypass_coll_a", 32'(coll[0]), 32'd0);
        chk("bypass_coll_b", 32'(coll[1]), 32'd0);
        tick();
        chk("bypass_wf0", dout[1][0], 32'h0);
        chk("bypass_wf0_vld", 32'(vld[1][0]), 32'd1);
        tick();

        // randomized traffic, concentrated on a few addresses, rare resets
        for (int i = 0; i < 3000; i++) begin
            en0   = 1'($urandom_range(0, 1));
            wen0  = 1'($urandom_range(0, 1));
            be0   = 4'($urandom_range(0, 15));
            addr0 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(16, 23));
            din0  = $urandom;
            en1   = 1'($urandom_range(0, 1));
            wen1  = 1'($urandom_range(0, 1));
            be1   = 4'($urandom_range(0, 15));
            addr1 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(16, 23));
            din1  = $urandom;
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 300 && busy[0]; i++) tick();
        tick();

        // reset one cycle after a read: the RD_LAT=2 result must be squashed
        set_port(0, 1'b1, 1'b0, 4'h0, 7'd5, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        chk("squash_lat1_vld", 32'(vld[0][0]), 32'd1);
        tick();
        chk("squash_lat2_vld", 32'(vld[1][0]), 32'd0);
        tick();
        chk("squash_lat2_vld_late", 32'(vld[1][0]), 32'd0);
        rst_n = 1'b1;
        count_busy("init_after_run_reset");

        // reset in the middle of the sweep restarts it
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        count_busy("init_after_mid_sweep_reset");
        rd_check(1, 7'd20, IV);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
